// File: rtl/xadac_vrf_sb.sv
// XADAC vector register file: async read ports, byte-masked write port, pending-write scoreboard, clear engine.
// Optional build macro XADAC_VRF_BYPASS_EN forwards a same-cycle accepted write onto matching read ports.
module xadac_vrf_sb #(
    parameter int unsigned NumRead = 3,
    parameter int unsigned NumRegs = 24,
    parameter int unsigned IdBits  = 5,
    parameter int unsigned VecBits = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    output logic                       ready,
    input  logic [NumRead*IdBits-1:0]  rid,
    output logic [NumRead*VecBits-1:0] rdata,
    input  logic [IdBits-1:0]          wid,
    input  logic [VecBits-1:0]         wdata,
    input  logic [VecBits/8-1:0]       wbe,
    input  logic                       we,
    input  logic                       rsv_valid,
    input  logic [IdBits-1:0]          rsv_id,
    output logic                       rsv_ready,
    output logic [NumRegs-1:0]         busy
);
    localparam int unsigned       NumBytes = VecBits / 8;
    localparam logic [IdBits:0]   RegsLim  = (IdBits + 1)'(NumRegs);
    localparam logic [IdBits-1:0] LastIdx  = IdBits'(NumRegs - 1);
    localparam logic              ST_CLEAR = 1'b0;
    localparam logic              ST_IDLE  = 1'b1;

    logic                state;
    logic [IdBits-1:0]   clr_ptr;
    logic [VecBits-1:0]  vrf [NumRegs];
    logic                wid_ok;
    logic                rsv_ok;
    logic                wr_ok;
    logic                rsv_hit;
    logic [NumRegs-1:0]  busy_set;
    logic [NumRegs-1:0]  busy_clr;

    assign ready  = (state == ST_IDLE);
    assign wid_ok = ({1'b0, wid} < RegsLim);
    assign rsv_ok = ({1'b0, rsv_id} < RegsLim);
    assign wr_ok  = ready & we & wid_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_ptr == LastIdx) begin
                state   <= ST_IDLE;
                clr_ptr <= '0;
            end else begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end else if (clr) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end
    end

    // Array has no reset; the clear engine is what initialises it.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            vrf[clr_ptr] <= '0;
        end else if (wr_ok) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wbe[b]) vrf[wid][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // A grant only happens when the bit is clear, so set-over-clear gives "reserve wins".
    always_comb begin
        rsv_hit  = 1'b0;
        busy_set = '0;
        busy_clr = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (rsv_id == IdBits'(i)) rsv_hit = busy[i];
            if (wr_ok && (wid == IdBits'(i))) busy_clr[i] = 1'b1;
        end
        rsv_ready = ready & rsv_valid & rsv_ok & ~rsv_hit;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (rsv_ready && (rsv_id == IdBits'(i))) busy_set[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else if (!ready || clr) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    for (genvar p = 0; p < NumRead; p++) begin : g_rd
        logic [IdBits-1:0]  id;
        logic [VecBits-1:0] val;

        assign id = rid[p*IdBits +: IdBits];

        always_comb begin
            val = '0;
            if (ready && ({1'b0, id} < RegsLim)) begin
                val = vrf[id];
`ifdef XADAC_VRF_BYPASS_EN
                if (wr_ok && (wid == id)) begin
                    for (int unsigned b = 0; b < NumBytes; b++) begin
                        if (wbe[b]) val[b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
`endif
            end
        end

        assign rdata[p*VecBits +: VecBits] = val;
    end

endmodule

// File: tb/tb_xadac_vrf_sb.sv
// Self-checking bench for xadac_vrf_sb: directed scenarios plus randomized traffic against an array/bit model.
module tb_xadac_vrf_sb;
    localparam int NR    = 3;
    localparam int NREGS = 24;
    localparam int IDB   = 5;
    localparam int VB    = 64;
    localparam int NB    = VB / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              clr;
    logic              ready;
    logic [NR*IDB-1:0] rid;
    logic [NR*VB-1:0]  rdata;
    logic [IDB-1:0]    wid;
    logic [VB-1:0]     wdata;
    logic [NB-1:0]     wbe;
    logic              we;
    logic              rsv_valid;
    logic [IDB-1:0]    rsv_id;
    logic              rsv_ready;
    logic [NREGS-1:0]  busy;

    int checks = 0;
    int errors = 0;

    logic [VB-1:0] mem [NREGS];
    bit            mbusy [NREGS];

    xadac_vrf_sb #(
        .NumRead(NR),
        .NumRegs(NREGS),
        .IdBits (IDB),
        .VecBits(VB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .ready    (ready),
        .rid      (rid),
        .rdata    (rdata),
        .wid      (wid),
        .wdata    (wdata),
        .wbe      (wbe),
        .we       (we),
        .rsv_valid(rsv_valid),
        .rsv_id   (rsv_id),
        .rsv_ready(rsv_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VB-1:0] merge(input logic [VB-1:0] old, input logic [VB-1:0] nw,
                                            input logic [NB-1:0] be);
        logic [VB-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Expected read value in IDLE for register id, given the currently driven write inputs.
    function automatic logic [VB-1:0] exp_read(input int id);
        logic [VB-1:0] v;
        if (id >= NREGS) return '0;
        v = mem[id];
`ifdef XADAC_VRF_BYPASS_EN
        if (we && int'(wid) == id) v = merge(v, wdata, wbe);
`endif
        return v;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic bit exp_grant();
        return rsv_valid && int'(rsv_id) < NREGS && !mbusy[rsv_id];
    endfunction

    // One IDLE clock: advance the model by the rules for the inputs currently driven.
    task automatic tick();
        bit g;
        g = exp_grant();
        @(posedge clk);
        #1;
        if (we && int'(wid) < NREGS) begin
            mem[wid]   = merge(mem[wid], wdata, wbe);
            mbusy[wid] = 1'b0;
        end
        if (g) mbusy[rsv_id] = 1'b1;
    endtask

    task automatic quiet();
        clr = 1'b0; we = 1'b0; rsv_valid = 1'b0; wbe = '0; wdata = '0; wid = '0; rsv_id = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            mem[i]   = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        quiet();
        rid  = '0;
        rstn = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || busy !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%h, required ready=0 busy=0", ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_clear();
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != NREGS) begin
            errors++;
            $display("FAIL reset_clear_len: cycles=%0d, required %0d", n, NREGS);
        end
        for (int id = 0; id < NREGS; id += NR) begin
            for (int p = 0; p < NR; p++) rid[p*IDB +: IDB] = IDB'(id + p);
            #1;
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rdata[p*VB +: VB] !== exp_read(id + p)) begin
                    errors++;
                    $display("FAIL reset_rdata reg %0d: got %h, required %h", id + p,
                             rdata[p*VB +: VB], exp_read(id + p));
                end
            end
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL reset_busy: got %h, required 0", busy);
        end
    endtask

    task automatic test_write_mask();
        quiet();
        we = 1'b1; wid = 5; wdata = {NB{8'hA5}}; wbe = '1;
        tick();
        wdata = {NB{8'hFF}}; wbe = 8'h01;
        tick();
        wdata = '0; wbe = '0;
        tick();
        quiet();
        rid[0 +: IDB] = 5;
        #1;
        checks++;
        if (rdata[0 +: VB] !== 64'hA5A5_A5A5_A5A5_A5FF) begin
            errors++;
            $display("FAIL write_mask: got %h, required a5a5a5a5a5a5a5ff", rdata[0 +: VB]);
        end
    endtask

    task automatic test_reserve();
        quiet();
        rsv_valid = 1'b1; rsv_id = 7;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++; $display("FAIL rsv_first: rsv_ready=%b, required 1", rsv_ready);
        end
        tick();
        checks++;
        if (busy[7] !== 1'b1 || rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsv_busy: busy7=%b rsv_ready=%b, required 1 0", busy[7], rsv_ready);
        end
        tick();
        we = 1'b1; wid = 7; wbe = '0;
        #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            errors++; $display("FAIL rsv_stall_on_release: rsv_ready=%b, required 0", rsv_ready);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (busy[7] !== 1'b0 || rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_release: busy7=%b rsv_ready=%b, required 0 1", busy[7], rsv_ready);
        end
        tick();
        checks++;
        if (busy !== exp_busy()) begin
            errors++; $display("FAIL rsv_regrant: busy=%h, required %h", busy, exp_busy());
        end
        quiet();
        we = 1'b1; wid = 7;
        tick();
        quiet();
    endtask

    task automatic test_same_id();
        quiet();
        rsv_valid = 1'b1; rsv_id = 3; we = 1'b1; wid = 3; wbe = '1; wdata = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++; $display("FAIL same_id_free: rsv_ready=%b, required 1", rsv_ready);
        end
        tick();
        checks++;
        if (busy[3] !== 1'b1) begin
            errors++; $display("FAIL same_id_reserve_wins: busy3=%b, required 1", busy[3]);
        end
        #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            errors++; $display("FAIL same_id_busy: rsv_ready=%b, required 0", rsv_ready);
        end
        tick();
        checks++;
        if (busy[3] !== 1'b0) begin
            errors++; $display("FAIL same_id_release: busy3=%b, required 0", busy[3]);
        end
        quiet();
    endtask

    task automatic test_random();
        int id;
        bit held;
        quiet();
        held = 1'b0;
        for (int it = 0; it < 400; it++) begin
            for (int p = 0; p < NR; p++) rid[p*IDB +: IDB] = IDB'($urandom_range(0, 27));
            we    = ($urandom_range(0, 2) != 0);
            wid   = IDB'($urandom_range(0, 27));
            wdata = {$urandom, $urandom};
            wbe   = NB'($urandom);
            if (!held || int'(rsv_id) >= NREGS) begin
                rsv_valid = ($urandom_range(0, 1) != 0);
                rsv_id    = IDB'($urandom_range(0, 27));
            end
            #2;
            checks++;
            if (rsv_ready !== exp_grant()) begin
                errors++;
                $display("FAIL rand_rsv_ready it=%0d id=%0d: got %b, required %b", it, rsv_id,
                         rsv_ready, exp_grant());
            end
            for (int p = 0; p < NR; p++) begin
                id = int'(rid[p*IDB +: IDB]);
                checks++;
                if (rdata[p*VB +: VB] !== exp_read(id)) begin
                    errors++;
                    $display("FAIL rand_rdata it=%0d port=%0d reg=%0d: got %h, required %h", it, p, id,
                             rdata[p*VB +: VB], exp_read(id));
                end
            end
            held = rsv_valid && !exp_grant();
            tick();
            checks++;
            if (busy !== exp_busy()) begin
                errors++;
                $display("FAIL rand_busy it=%0d: got %h, required %h", it, busy, exp_busy());
            end
        end
        quiet();
    endtask

    task automatic test_clear();
        int n;
        quiet();
        we = 1'b1; wid = 2; wbe = '0;
        tick();
        quiet();
        rsv_valid = 1'b1; rsv_id = 2;
        tick();
        quiet();
        we = 1'b1; wid = 9; wbe = '1; wdata = {NB{8'h5A}};
        tick();
        quiet();
        rid[0 +: IDB] = 9;
        #1;
        checks++;
        if (busy[2] !== 1'b1 || rdata[0 +: VB] !== {NB{8'h5A}}) begin
            errors++;
            $display("FAIL clear_setup: busy2=%b rdata=%h, required 1 %h", busy[2], rdata[0 +: VB],
                     {NB{8'h5A}});
        end
        clr = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL clr_comb_path: ready=%b, required 1", ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            we = 1'b1; wid = 9; wbe = '1; wdata = {$urandom, $urandom};
            rsv_valid = 1'b1; rsv_id = IDB'($urandom_range(0, NREGS - 1));
            clr = (n == 3);
            #1;
            checks++;
            if (rsv_ready !== 1'b0 || rdata[0 +: VB] !== '0 || busy !== '0) begin
                errors++;
                $display("FAIL clear_busy_phase n=%0d: rsv_ready=%b rdata=%h busy=%h, required 0 0 0", n,
                         rsv_ready, rdata[0 +: VB], busy);
            end
            @(posedge clk);
            #1;
            n++;
        end
        quiet();
        checks++;
        if (n != NREGS) begin
            errors++; $display("FAIL clear_len: cycles=%0d, required %0d", n, NREGS);
        end
        #1;
        checks++;
        if (busy !== '0 || rdata[0 +: VB] !== '0) begin
            errors++;
            $display("FAIL clear_after: busy=%h rdata9=%h, required 0 0", busy, rdata[0 +: VB]);
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        repeat (5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != NREGS) begin
            errors++; $display("FAIL reset_midclear_len: cycles=%0d, required %0d", n, NREGS);
        end
    endtask

    task automatic test_bypass();
        logic [VB-1:0] want;
        quiet();
        we = 1'b1; wid = 4; wbe = '1; wdata = {NB{8'h22}};
        tick();
        wdata = {NB{8'h11}};
        rid[0 +: IDB] = 4;
        #1;
`ifdef XADAC_VRF_BYPASS_EN
        want = {NB{8'h11}};
`else
        want = {NB{8'h22}};
`endif
        checks++;
        if (rdata[0 +: VB] !== want) begin
            errors++; $display("FAIL bypass_same_cycle: got %h, required %h", rdata[0 +: VB], want);
        end
        tick();
        quiet();
        #1;
        checks++;
        if (rdata[0 +: VB] !== {NB{8'h11}}) begin
            errors++; $display("FAIL bypass_next_cycle: got %h, required %h", rdata[0 +: VB], {NB{8'h11}});
        end
    endtask

    initial begin
        test_reset();
        test_write_mask();
        test_reserve();
        test_same_id();
        test_random();
        test_bypass();
        test_clear();
        test_reset_midclear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
